// File: rtl/receptor_serial_alineado.sv
// Serial-to-parallel receiver that aligns 10-bit words on K28.5 commas and
// tracks lock with a SEARCH/CHECK/LOCKED state machine.
module receptor_serial_alineado #(
  parameter logic [9:0]  COMMA_NEG   = 10'b0011111010,
  parameter logic [9:0]  COMMA_POS   = 10'b1100000101,
  parameter int unsigned LOCK_COMMAS = 3,
  parameter int unsigned LOSS_COUNT  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entrada,
  output logic [9:0] salidas,
  output logic       valida,
  output logic       sincronizado,
  output logic       es_coma
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

  state_t     state_q;
  logic [8:0] hist_q;
  logic [3:0] cnt_q;
  logic [3:0] good_q;
  logic [3:0] mis_q;
  logic [9:0] salidas_q;
  logic       valida_q;
  logic       sinc_q;
  logic       coma_q;

  logic [9:0] win;
  logic       comma_det;
  logic       boundary;

  assign win       = {hist_q, entrada};
  // Case equality keeps unknown input bits from ever matching a comma.
  assign comma_det = (win === COMMA_NEG) || (win === COMMA_POS);
  assign boundary  = (cnt_q == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      hist_q    <= '0;
      cnt_q     <= '0;
      good_q    <= '0;
      mis_q     <= '0;
      salidas_q <= '0;
      valida_q  <= 1'b0;
      sinc_q    <= 1'b0;
      coma_q    <= 1'b0;
    end else begin
      hist_q   <= win[8:0];
      cnt_q    <= boundary ? 4'd0 : cnt_q + 4'd1;
      valida_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (comma_det) begin
            cnt_q  <= '0;
            good_q <= 4'd1;
            if (LOCK_N == 4'd1) begin
              state_q <= LOCKED;
              mis_q   <= '0;
              sinc_q  <= 1'b1;
            end else begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          if (boundary) begin
            if (comma_det) begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_N) begin
                state_q <= LOCKED;
                mis_q   <= '0;
                sinc_q  <= 1'b1;
              end
            end else begin
              state_q <= SEARCH;
              good_q  <= '0;
            end
          end else if (comma_det) begin
            cnt_q  <= '0;
            good_q <= 4'd1;
          end
        end
        LOCKED: begin
          if (boundary) begin
            salidas_q <= win;
            coma_q    <= comma_det;
            valida_q  <= 1'b1;
            if (comma_det) begin
              mis_q <= '0;
            end
          end else if (comma_det) begin
            // Misaligned comma: counted, never used to re-align while locked.
            if (mis_q + 4'd1 == LOSS_N) begin
              state_q <= SEARCH;
              mis_q   <= '0;
              good_q  <= '0;
              sinc_q  <= 1'b0;
            end else begin
              mis_q <= mis_q + 4'd1;
            end
          end
        end
        default: begin
          state_q <= SEARCH;
          sinc_q  <= 1'b0;
        end
      endcase
    end
  end

  assign salidas      = salidas_q;
  assign valida       = valida_q;
  assign sincronizado = sinc_q;
  assign es_coma      = coma_q;

endmodule

// File: tb/tb_receptor_serial_alineado.sv
// Bench for receptor_serial_alineado: bit-position reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_receptor_serial_alineado;

  localparam logic [9:0] NEG  = 10'b0011111010;
  localparam logic [9:0] POS  = 10'b1100000101;
  localparam int         LOCK = 3;
  localparam int         LOSS = 2;

  logic       clk;
  logic       reset;
  logic       entrada;
  logic [9:0] salidas;
  logic       valida;
  logic       sincronizado;
  logic       es_coma;

  int nvec = 0;
  int nerr = 0;

  receptor_serial_alineado #(
    .COMMA_NEG  (NEG),
    .COMMA_POS  (POS),
    .LOCK_COMMAS(LOCK),
    .LOSS_COUNT (LOSS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entrada     (entrada),
    .salidas     (salidas),
    .valida      (valida),
    .sincronizado(sincronizado),
    .es_coma     (es_coma)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: word boundaries are expressed as bit positions since
  // reset relative to the last alignment point, not as a wrapping counter.
  logic [9:0] m_win;
  logic [9:0] m_sal;
  logic       m_val, m_coma, m_sync, m_init;
  int         m_n, m_a, m_good, m_mis, m_mode; // mode: 0 search, 1 check, 2 locked
  logic       m_isc, m_bnd;

  initial m_init = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_win = '0; m_n = 0; m_a = 0; m_good = 0; m_mis = 0; m_mode = 0;
      m_sal = '0; m_val = 1'b0; m_coma = 1'b0; m_init = 1'b1;
    end else if (m_init) begin
      m_win = {m_win[8:0], entrada};
      m_n   = m_n + 1;
      m_isc = (m_win === NEG) || (m_win === POS);
      m_bnd = ((m_n - m_a) % 10) == 0;
      m_val = 1'b0;
      if (m_mode == 0) begin
        if (m_isc) begin
          m_a = m_n; m_good = 1; m_mis = 0;
          m_mode = (LOCK == 1) ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (m_bnd && m_isc) begin
          m_good = m_good + 1;
          if (m_good == LOCK) begin m_mode = 2; m_mis = 0; end
        end else if (m_bnd) begin
          m_mode = 0; m_good = 0;
        end else if (m_isc) begin
          m_a = m_n; m_good = 1;
        end
      end else begin
        if (m_bnd) begin
          m_sal = m_win; m_coma = m_isc; m_val = 1'b1;
          if (m_isc) m_mis = 0;
        end else if (m_isc) begin
          m_mis = m_mis + 1;
          if (m_mis == LOSS) begin m_mode = 0; m_mis = 0; m_good = 0; end
        end
      end
    end
    m_sync = (m_mode == 2);
  end

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_init && !reset) begin
      check("model_salidas", salidas, m_sal);
      check("model_valida", {9'b0, valida}, {9'b0, m_val});
      check("model_sincronizado", {9'b0, sincronizado}, {9'b0, m_sync});
      check("model_es_coma", {9'b0, es_coma}, {9'b0, m_coma});
    end
  end

  task automatic apply_reset();
    reset   = 1'b1;
    entrada = 1'b0;
    @(posedge clk); #1;
    reset   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    entrada = b;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [9:0] w);
    for (int i = 9; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_salidas"}, salidas, 10'b0);
    check({tag, "_valida"}, {9'b0, valida}, 10'b0);
    check({tag, "_sinc"}, {9'b0, sincronizado}, 10'b0);
    check({tag, "_es_coma"}, {9'b0, es_coma}, 10'b0);
  endtask

  logic [9:0] xw;

  initial begin
    reset   = 1'b1;
    entrada = 1'b0;
    @(posedge clk); #1;

    // Basic lock on three aligned commas, then a data word.
    apply_reset();
    check_zero("reset");
    send_word(NEG); send_word(NEG);
    check("lock_pre_sinc", {9'b0, sincronizado}, 10'b0);
    send_word(NEG);
    check("lock_sinc", {9'b0, sincronizado}, 10'b1);
    send_word(10'b1010010101);
    check("data_salidas", salidas, 10'b1010010101);
    check("data_valida", {9'b0, valida}, 10'b1);
    check("data_es_coma", {9'b0, es_coma}, 10'b0);

    // Three slip bits: first misaligned comma holds lock, second drops it.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check("slip_valida_pulse", {9'b0, valida}, 10'b0);
    send_word(NEG);
    check("slip1_sinc", {9'b0, sincronizado}, 10'b1);
    send_word(NEG);
    check("slip2_sinc", {9'b0, sincronizado}, 10'b0);
    send_word(NEG); send_word(NEG);
    check("relock_pre_sinc", {9'b0, sincronizado}, 10'b0);
    send_word(NEG);
    check("relock_sinc", {9'b0, sincronizado}, 10'b1);

    // Word with unknown bits while locked.
    xw = 10'bx10x10x10x;
    send_word(xw);
    check("xword_valida", {9'b0, valida}, 10'b1);
    check("xword_es_coma", {9'b0, es_coma}, 10'b0);
    check("xword_sinc", {9'b0, sincronizado}, 10'b1);
    send_word(NEG);
    check("after_x_salidas", salidas, NEG);
    check("after_x_es_coma", {9'b0, es_coma}, 10'b1);

    // Reset in the middle of a word while locked.
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    apply_reset();
    check_zero("midreset");
    send_word(NEG); send_word(NEG);
    check("midreset_relock_pre", {9'b0, sincronizado}, 10'b0);
    send_word(NEG);
    check("midreset_relock", {9'b0, sincronizado}, 10'b1);

    // Lock behind a 4-bit offset with alternating disparity commas.
    apply_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_word(POS); send_word(NEG); send_word(POS);
    check("offset_sinc", {9'b0, sincronizado}, 10'b1);
    send_word(10'b1111100000);
    check("offset_salidas", salidas, 10'b1111100000);
    check("offset_valida", {9'b0, valida}, 10'b1);

    // One comma then data while checking: back to search.
    apply_reset();
    send_word(NEG);
    send_word(10'b0000011111);
    check("check_fail_sinc", {9'b0, sincronizado}, 10'b0);
    check("check_fail_salidas", salidas, 10'b0);
    send_word(NEG); send_word(NEG); send_word(NEG);
    check("check_fail_relock", {9'b0, sincronizado}, 10'b1);

    repeat (3) send_bit(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/receptor_serial_alineado.md
RECEPTOR_SERIAL_ALINEADO -- requirements
Module: receptor_serial_alineado

Interface
REQ-001 Parameter COMMA_NEG, default 10'b0011111010, meaning: K28.5 comma, negative running disparity.
REQ-002 Parameter COMMA_POS, default 10'b1100000101, meaning: K28.5 comma, positive running disparity.
REQ-003 Parameter LOCK_COMMAS, default 3, meaning: consecutive aligned commas required to declare lock (range 1-15).
REQ-004 Parameter LOSS_COUNT, default 2, meaning: consecutive misaligned commas that drop lock (range 1-15).
REQ-005 Port clk, input, 1, meaning: single bit clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1, meaning: synchronous, active-high reset.
REQ-007 Port entrada, input, 1, meaning: serial bit stream, one bit per clk, first bit of each word is word bit 9 (MSB-first).
REQ-008 Port salidas, output, 10, meaning: last complete aligned 10-bit word, registered.
REQ-009 Port valida, output, 1, meaning: one-cycle pulse when salidas is updated while locked.
REQ-010 Port sincronizado, output, 1, meaning: high while FSM is in LOCKED.
REQ-011 Port es_coma, output, 1, meaning: registered flag, salidas holds COMMA_NEG or COMMA_POS.

Function
REQ-012 The block SHALL keep a 9-bit history register; the window W = {history[8:0], entrada} SHALL be the 10 most recent bits, and history SHALL shift to W[8:0] every cycle.
REQ-013 comma_det SHALL be the combinational result W == COMMA_NEG or W == COMMA_POS.
REQ-014 A bit counter 0..9 SHALL increment every cycle and wrap 9->0; "boundary" means counter == 9 in that cycle.
REQ-015 The FSM SHALL have states SEARCH, CHECK, LOCKED.
REQ-016 SEARCH: on comma_det, the counter SHALL be forced to 0 for the next cycle, the good-comma count set to 1, and the state go to CHECK (or to LOCKED if LOCK_COMMAS == 1); otherwise it SHALL remain in SEARCH.
REQ-017 CHECK: at boundary with comma_det, good count SHALL increment; on reaching LOCK_COMMAS the state SHALL go to LOCKED.
REQ-018 CHECK: at boundary without comma_det, state SHALL return to SEARCH and good count clear.
REQ-019 CHECK: comma_det at non-boundary SHALL re-align (counter forced to 0 next cycle, good count = 1), staying in CHECK.
REQ-020 LOCKED: at every boundary, salidas <= W, es_coma <= comma_det, valida = 1 for exactly the following cycle.
REQ-021 LOCKED: comma_det at boundary SHALL clear the misalign count.
REQ-022 LOCKED: comma_det at non-boundary SHALL increment misalign count; on reaching LOSS_COUNT the state SHALL go to SEARCH with counters cleared, and no counter re-alignment occurs in that cycle.
REQ-023 Data words (non-comma) at boundary in LOCKED SHALL NOT affect the misalign count.
REQ-024 salidas, es_coma SHALL hold their values outside boundaries and in SEARCH/CHECK; valida SHALL be 0 outside LOCKED.
REQ-025 Latency: the 10th bit of a word sampled at edge N SHALL appear on salidas, with valida high, immediately after edge N.
REQ-026 sincronizado SHALL be registered from the state, rising the cycle after the transition into LOCKED and falling the cycle after leaving it.
REQ-027 Unknown (x) bits on entrada SHALL NOT produce comma_det; they may propagate to salidas only in LOCKED.

Reset
REQ-028 With reset high at a clk edge: state = SEARCH, history = 0, counter = 0, good and misalign counts = 0, salidas = 10'b0, valida = 0, sincronizado = 0, es_coma = 0.
REQ-029 Reset SHALL take priority over every other event, including a comma_det in the same cycle; reset mid-word discards the partial word.

Verification
REQ-030 Reset, then 3x COMMA_NEG MSB-first, then 10'b1010010101 -> sincronizado high after 30th bit, then salidas = 10'b1010010101, valida one cycle, es_coma = 0.
REQ-031 4 random bits, then COMMA_POS, COMMA_NEG, COMMA_POS, 10'b1111100000 -> lock on correct boundary despite 4-bit offset; salidas = 10'b1111100000.
REQ-032 While in CHECK after 1 comma, send 10'b0000011111 -> return to SEARCH, sincronizado stays 0.
REQ-033 Locked stream, insert 3 extra bits then commas -> first misaligned comma keeps lock, second drops sincronizado; relock after 3 aligned commas.
REQ-034 Locked, send 10'bx10x10x10x -> no lock loss, valida pulses, es_coma = 0.
REQ-035 Assert reset mid-word in LOCKED -> all outputs 0 next cycle, relock requires full 3-comma sequence.
